regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers; power of two, minimum 2.
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 Parameter AW, default clog2(NREGS), register address width.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-009 rd_data  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
REQ-010 rd_busy  out  NRD  set when the register read on port k has an outstanding reservation.
REQ-011 wr_en  in  NWR  per-port write enable.
REQ-012 wr_addr  in  NWR*AW  write addresses; port j occupies bits [j*AW +: AW].
REQ-013 wr_data  in  NWR*XLEN  write data; port j occupies bits [j*XLEN +: XLEN].
REQ-014 rsv_en  in  1  reserve destination register rsv_addr (issue of an in-flight producer).
REQ-015 rsv_addr  in  AW  register to reserve.
REQ-016 flush  in  1  synchronous clear of all reservations.
REQ-017 busy_cnt  out  AW+1  number of registers currently reserved.

Function
REQ-018 Register 0 SHALL read as zero, SHALL ignore writes and SHALL never be reserved; rsv_en with rsv_addr=0 has no effect.
REQ-019 Writes SHALL be synchronous: wr_data[j] is stored at the rising edge where wr_en[j]=1.
REQ-020 If several write ports target the same register in one cycle, the highest-numbered port SHALL win.
REQ-021 Reads SHALL be combinational, with write-through bypass: when wr_en[j]=1 and wr_addr[j] equals rd_addr[k] (nonzero), rd_data[k] SHALL equal wr_data[j] in the same cycle, applying the priority of REQ-020.
REQ-022 A write on any port SHALL clear the busy bit of its register at the same edge.
REQ-023 rsv_en SHALL set the busy bit of rsv_addr at the next edge.
REQ-024 When a reservation and a write target the same register in the same cycle, the reservation SHALL win and the bit ends set (the new producer supersedes the old one).
REQ-025 rd_busy[k] SHALL reflect the registered busy bit, cleared combinationally when a same-cycle write to that register is present and no same-cycle reservation targets it (consistent with the bypass).
REQ-026 flush SHALL clear every busy bit at the next edge and SHALL override same-cycle rsv_en; same-cycle writes still update data.
REQ-027 busy_cnt SHALL be a registered population count of the busy vector, updated at the same edge as the vector and valid in the cycle after the change; its range is 0..NREGS-1.
REQ-028 Reserving an already-busy register SHALL leave it busy and SHALL leave busy_cnt unchanged.
REQ-029 Out-of-range conditions do not exist: all AW-bit addresses are valid.

Reset
REQ-030 While rst_n=0, all registers SHALL be zero, all busy bits zero and busy_cnt zero, regardless of clk.
REQ-031 Reset asserted during a write or reservation SHALL discard it; the first edge after deassertion is the first functional edge.
REQ-032 Outputs during reset: rd_data zero, or the bypass value when a write is presented; rd_busy zero.

Structure
REQ-033 Shared package regfile_pkg SHALL hold the default XLEN/NREGS/NRD/NWR constants and the clog2 helper function.
REQ-034 One sub-module, rf_read_port (bypass mux plus busy resolution for one read port), SHALL be instantiated NRD times via generate.
REQ-035 Storage SHALL cover registers 1..NREGS-1 only.

Verification
REQ-036 Reset, then read all addresses -> every rd_data=0, rd_busy=0, busy_cnt=0.
REQ-037 Write port0 r5=0xDEADBEEF with rd_addr0=5 in the same cycle -> rd_data0=0xDEADBEEF in that cycle and after the edge.
REQ-038 Same cycle: port0 writes r7=0x11, port1 writes r7=0x22 -> bypass and stored value are 0x22.
REQ-039 rsv_en r3, next cycle -> rd_busy=1, busy_cnt=1; then write r3 while rsv_en r3 -> r3 stays busy; then write r3 alone -> busy clears, busy_cnt=0.
REQ-040 Reserve r1, r2, r4 over successive cycles, then flush with rsv_en r6 -> busy_cnt=0 and r6 not busy.
REQ-041 Write r0=0xFFFFFFFF and rsv_en r0 -> r0 reads 0, rd_busy=0; pulse rst_n low mid-write to r9 -> r9=0 after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with reservation scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 2;

    // Smallest width able to index 'value' entries; elaboration-time only.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle between the register file and its user: read, write, reserve and flush.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF,
    parameter int AW    = clog2(NREGS)
);

    // No handshake: every request is accepted at the edge it is presented,
    // and reads/busy flags are valid combinationally in the same cycle.
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                flush;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/rf_read_port.sv
// One read port: write-through bypass (highest write port wins) and busy-bit resolution.
module rf_read_port #(
    parameter int XLEN = 32,
    parameter int NWR  = 2,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]       rd_addr_i,
    input  logic [XLEN-1:0]     stored_i,
    input  logic                busy_i,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                rsv_en_i,
    input  logic [AW-1:0]       rsv_addr_i,
    output logic [XLEN-1:0]     rd_data_o,
    output logic                rd_busy_o
);

    logic            is_zero;
    logic            wr_hit;
    logic            rsv_hit;
    logic [XLEN-1:0] byp_data;

    assign is_zero = (rd_addr_i == '0);
    assign rsv_hit = rsv_en_i && (rsv_addr_i == rd_addr_i) && !is_zero;

    // Ascending scan so a later (higher-numbered) port overrides earlier matches.
    always_comb begin
        wr_hit   = 1'b0;
        byp_data = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
                wr_hit   = 1'b1;
                byp_data = wr_data_i[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rd_data_o = stored_i;
        if (is_zero) begin
            rd_data_o = '0;
        end else if (wr_hit) begin
            rd_data_o = byp_data;
        end
    end

    // A same-cycle write retires the producer unless a new one is issued alongside it.
    assign rd_busy_o = busy_i && !(wr_hit && !is_zero && !rsv_hit);

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a per-register reservation (busy) scoreboard and busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF,
    parameter int AW    = clog2(NREGS)
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave bus_if
);

    // Register 0 is hardwired to zero, so storage starts at index 1.
    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [XLEN-1:0]  regs_d [1:NREGS-1];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    // Priority of busy updates: write clears, reservation sets, flush clears all.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (bus_if.wr_en[j] && (bus_if.wr_addr[j*AW +: AW] != '0)) begin
                regs_d[bus_if.wr_addr[j*AW +: AW]] = bus_if.wr_data[j*XLEN +: XLEN];
                busy_d[bus_if.wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (bus_if.rsv_en && (bus_if.rsv_addr != '0)) begin
            busy_d[bus_if.rsv_addr] = 1'b1;
        end
        if (bus_if.flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int r = 1; r < NREGS; r++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus_if.busy_cnt = cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] stored;
        logic [XLEN-1:0] rdata;
        logic            rbusy;

        assign addr   = bus_if.rd_addr[k*AW +: AW];
        assign stored = (addr == '0) ? '0 : regs_q[addr];

        rf_read_port #(
            .XLEN (XLEN),
            .NWR  (NWR),
            .AW   (AW)
        ) u_rd_port (
            .rd_addr_i  (addr),
            .stored_i   (stored),
            .busy_i     (busy_q[addr]),
            .wr_en_i    (bus_if.wr_en),
            .wr_addr_i  (bus_if.wr_addr),
            .wr_data_i  (bus_if.wr_data),
            .rsv_en_i   (bus_if.rsv_en),
            .rsv_addr_i (bus_if.rsv_addr),
            .rd_data_o  (rdata),
            .rd_busy_o  (rbusy)
        );

        assign bus_if.rd_data[k*XLEN +: XLEN] = rdata;
        assign bus_if.rd_busy[k]              = rbusy;
    end

endmodule
